// File: rtl/lut3_cfg_ctrl.sv
// Configuration controller for a bank of 3-input LUTs.
// A serial bitstream is collected in a shadow register and committed to the
// active truth tables in one edge. The selected LUT is evaluated every cycle
// into a registered output.

module lut3_cell (
   input  logic [7:0] tbl,
   input  logic [2:0] idx,
   output logic       y
);
   assign y = tbl[idx];
endmodule

module lut3_cfg_ctrl #(
   parameter int NUM_LUTS = 4,
   parameter int SEL_W    = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_start,
   input  logic             cfg_bit,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   output logic             cfg_done,
   output logic             cfg_err,
   input  logic [SEL_W-1:0] lut_sel,
   input  logic             A,
   input  logic             B,
   input  logic             C,
   output logic             OUT,
   output logic             out_valid
);
   localparam int TOT   = 8 * NUM_LUTS;
   localparam int CNT_W = $clog2(TOT);

   typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;

   state_t                  state;
   logic [TOT-1:0]          act_tbl;
   logic [TOT-1:0]          shd_tbl;
   logic [TOT-1:0]          shd_next;
   logic [CNT_W-1:0]        bit_cnt;
   logic                    last_bit;
   logic [NUM_LUTS-1:0]     cell_out;
   logic [(1<<SEL_W)-1:0]   cell_pad;

   // Bit k of the flat table vector is LUT k/8, table bit k%8.
   assign last_bit = (bit_cnt == CNT_W'(TOT-1));

   // Shadow image with the incoming bit merged at the current position.
   always_comb begin
      shd_next          = shd_tbl;
      shd_next[bit_cnt] = cfg_bit;
   end

   genvar i;
   generate
      for (i = 0; i < NUM_LUTS; i++) begin : g_cell
         lut3_cell u_cell (
            .tbl (act_tbl[8*i +: 8]),
            .idx ({C, B, A}),
            .y   (cell_out[i])
         );
      end
   endgenerate

   // Out-of-range selects read the zero padding.
   always_comb begin
      cell_pad                 = '0;
      cell_pad[NUM_LUTS-1:0]   = cell_out;
   end

   // Load FSM, commit and registered evaluation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         act_tbl   <= '0;
         shd_tbl   <= '0;
         bit_cnt   <= '0;
         cfg_ready <= 1'b0;
         cfg_done  <= 1'b0;
         cfg_err   <= 1'b0;
         OUT       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         OUT       <= cell_pad[lut_sel];
         out_valid <= cfg_done;
         case (state)
            IDLE, ACTIVE: begin
               if (cfg_start) begin
                  state     <= LOAD;
                  cfg_ready <= 1'b1;
                  bit_cnt   <= '0;
                  shd_tbl   <= '0;
               end
            end
            LOAD: begin
               if (cfg_start) begin
                  // Abort wins over any bit presented on the same edge.
                  bit_cnt <= '0;
                  shd_tbl <= '0;
                  cfg_err <= 1'b1;
               end else if (cfg_valid) begin
                  shd_tbl <= shd_next;
                  if (last_bit) begin
                     act_tbl   <= shd_next;
                     bit_cnt   <= '0;
                     cfg_done  <= 1'b1;
                     cfg_err   <= 1'b0;
                     cfg_ready <= 1'b0;
                     state     <= ACTIVE;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               cfg_ready <= 1'b0;
            end
         endcase
      end
   end
endmodule
